fp_divsqrt_unit: RTL and testbench
==================================

FP_DIVSQRT_UNIT -- requirements
Module: fp_divsqrt_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width, two's complement.
REQ-002 SHALL have parameter FRAC_BITS, default 16: fractional bits, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: request valid.
REQ-006 SHALL have port in_ready, output, 1: unit can accept a request.
REQ-007 SHALL have port op, input, 1: 0 = divide a/b, 1 = square root of a.
REQ-008 SHALL have ports a and b, input, DATA_WIDTH each: signed operands; b is ignored for sqrt.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port result, output, DATA_WIDTH: signed fixed-point result.
REQ-012 SHALL have port div_by_zero, output, 1: divide request with b==0.
REQ-013 SHALL have port overflow, output, 1: result saturated.
REQ-014 SHALL have port domain_err, output, 1: sqrt of negative a, or sqrt requested while compiled out.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = (state==IDLE).
REQ-016 SHALL capture op, a and b, and enter CALC, on the edge where in_valid && in_ready.
REQ-017 Divide: magnitude |a|<<FRAC_BITS over |b| SHALL use restoring radix-2 division, one quotient bit per cycle, DATA_WIDTH+FRAC_BITS cycles in CALC.
REQ-018 Divide: quotient SHALL truncate toward zero; sign = sign(a) XOR sign(b).
REQ-019 Divide: if the signed quotient exceeds 2^(W-1)-1 or is below -2^(W-1), result SHALL saturate to 0x7FF..F or 0x800..0 respectively, with overflow=1.
REQ-020 Divide by zero: SHALL skip CALC and go to DONE on the next cycle, result = 0x7FF..F if a>=0 else 0x800..0, div_by_zero=1, overflow=1.
REQ-021 Sqrt: SHALL compute digit-by-digit integer sqrt of unsigned a<<FRAC_BITS, one result bit per cycle, (DATA_WIDTH+FRAC_BITS)/2 cycles in CALC, truncated.
REQ-022 Sqrt of a==0 SHALL give 0 through the normal path; sqrt of negative a SHALL skip CALC, giving result=0 and domain_err=1.
REQ-023 DATA_WIDTH+FRAC_BITS SHALL be even, and FRAC_BITS < DATA_WIDTH; violation SHALL raise an elaboration-time $error.
REQ-024 In DONE, out_valid=1 and result and all flags SHALL hold stable until out_ready=1; state then returns to IDLE on that edge.
REQ-025 A request SHALL NOT be accepted on the same cycle as the result handshake; in_ready rises the cycle after.
REQ-026 Flags SHALL be valid only while out_valid=1 and SHALL be 0 otherwise.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, out_valid=0, result=0, all flags=0, and in_ready=1 once reset releases.
REQ-028 Reset asserted during CALC or DONE SHALL abort the operation with no result emitted.

Configuration
REQ-029 Macro FP_DIVSQRT_SQRT_EN defined: sqrt datapath SHALL be present as specified above.
REQ-030 Macro FP_DIVSQRT_SQRT_EN undefined: no sqrt logic; op=1 SHALL go to DONE on the next cycle with result=0 and domain_err=1.

Verification
REQ-031 Divide 0x00060000 / 0x00020000 -> result 0x00030000 exactly 48 cycles after accept, all flags 0.
REQ-032 Divide 0x00010000 / 0 -> result 0x7FFFFFFF with div_by_zero=1 and overflow=1; divide 0xFFFF0000 / 0 -> result 0x80000000.
REQ-033 Divide 0x7FFF0000 / 0x00008000 -> result 0x7FFFFFFF with overflow=1; divide 0xFFFA0000 / 0x00020000 -> result 0xFFFD0000.
REQ-034 Sqrt 0x00040000 -> result 0x00020000 after 24 cycles; sqrt 0x00020000 -> 0x00016A09; sqrt 0x80000000 -> 0 with domain_err=1.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0 throughout; rst_n pulsed mid-CALC -> out_valid never asserts and in_ready=1 after release.
REQ-036 Rebuild without FP_DIVSQRT_SQRT_EN: sqrt 0x00040000 -> result 0 with domain_err=1 one cycle after accept.

Source files
------------

// File: rtl/fp_divsqrt_unit.sv
// Iterative signed fixed-point divide / square-root unit with a valid/ready request and result handshake.
// Optional macro FP_DIVSQRT_SQRT_EN adds the square-root datapath; without it, sqrt requests return domain_err.
module fp_divsqrt_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  div_by_zero,
  output logic                  overflow,
  output logic                  domain_err
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned TOT   = DATA_WIDTH + FRAC_BITS;
  localparam int unsigned HALF  = TOT / 2;
  localparam int unsigned REM_W = DATA_WIDTH + 4;
  localparam int unsigned CW    = $clog2(TOT + 1);
  localparam logic [W-1:0]   MAX_RES = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   MIN_RES = {1'b1, {(W-1){1'b0}}};
  localparam logic [TOT-1:0] NEG_MAG = TOT'(1) << (W - 1);
  localparam logic [TOT-1:0] POS_MAX = NEG_MAG - TOT'(1);

  if ((((DATA_WIDTH + FRAC_BITS) % 2) != 0) || (FRAC_BITS >= DATA_WIDTH)) begin : g_cfg_err
    $error("fp_divsqrt_unit: DATA_WIDTH+FRAC_BITS must be even and FRAC_BITS < DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_n;
  logic             op_q, op_n;
  logic             neg_q, neg_n;
  logic [W-1:0]     mag_b, mag_b_n;
  logic [TOT-1:0]   shreg, shreg_n;
  logic [TOT-1:0]   quo, quo_n;
  logic [REM_W-1:0] rem, rem_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             in_ready_n, out_valid_n, dbz_n, ovf_n, dom_n;
  logic [W-1:0]     result_n;
  logic [W-1:0]     abs_a, abs_b;
  logic [REM_W-1:0] rem_sh, divisor;
`ifdef FP_DIVSQRT_SQRT_EN
  logic [REM_W-1:0] trial;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= 1'b0;
      neg_q       <= 1'b0;
      mag_b       <= '0;
      shreg       <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      domain_err  <= 1'b0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      neg_q       <= neg_n;
      mag_b       <= mag_b_n;
      shreg       <= shreg_n;
      quo         <= quo_n;
      rem         <= rem_n;
      cnt         <= cnt_n;
      in_ready    <= in_ready_n;
      out_valid   <= out_valid_n;
      result      <= result_n;
      div_by_zero <= dbz_n;
      overflow    <= ovf_n;
      domain_err  <= dom_n;
    end
  end

  // Next-state, iteration step and result formatting
  always_comb begin
    state_n     = state;
    op_n        = op_q;
    neg_n       = neg_q;
    mag_b_n     = mag_b;
    shreg_n     = shreg;
    quo_n       = quo;
    rem_n       = rem;
    cnt_n       = cnt;
    out_valid_n = out_valid;
    result_n    = result;
    dbz_n       = div_by_zero;
    ovf_n       = overflow;
    dom_n       = domain_err;
    abs_a       = a[W-1] ? (~a + W'(1)) : a;
    abs_b       = b[W-1] ? (~b + W'(1)) : b;
    rem_sh      = '0;
    divisor     = REM_W'(mag_b);
`ifdef FP_DIVSQRT_SQRT_EN
    trial       = '0;
`endif

    case (state)
      IDLE: begin
        if (in_valid) begin
          op_n    = op;
          neg_n   = a[W-1] ^ b[W-1];
          mag_b_n = abs_b;
          quo_n   = '0;
          rem_n   = '0;
          if (!op) begin
            shreg_n = TOT'(abs_a) << FRAC_BITS;
            cnt_n   = CW'(TOT);
            if (b == '0) begin
              state_n     = DONE;
              out_valid_n = 1'b1;
              result_n    = a[W-1] ? MIN_RES : MAX_RES;
              dbz_n       = 1'b1;
              ovf_n       = 1'b1;
            end else begin
              state_n = CALC;
            end
          end else begin
`ifdef FP_DIVSQRT_SQRT_EN
            shreg_n = TOT'(a) << FRAC_BITS;
            cnt_n   = CW'(HALF);
            if (a[W-1]) begin
              state_n     = DONE;
              out_valid_n = 1'b1;
              result_n    = '0;
              dom_n       = 1'b1;
            end else begin
              state_n = CALC;
            end
`else
            state_n     = DONE;
            out_valid_n = 1'b1;
            result_n    = '0;
            dom_n       = 1'b1;
`endif
          end
        end
      end

      CALC: begin
        cnt_n = cnt - CW'(1);
        if (op_q) begin
`ifdef FP_DIVSQRT_SQRT_EN
          // Bring down two radicand bits; accept the next root bit if (4*root+1) fits
          rem_sh  = {rem[REM_W-3:0], shreg[TOT-1:TOT-2]};
          trial   = (REM_W'(quo) << 2) | REM_W'(1);
          shreg_n = shreg << 2;
          if (rem_sh >= trial) begin
            rem_n = rem_sh - trial;
            quo_n = {quo[TOT-2:0], 1'b1};
          end else begin
            rem_n = rem_sh;
            quo_n = {quo[TOT-2:0], 1'b0};
          end
`endif
        end else begin
          rem_sh  = {rem[REM_W-2:0], shreg[TOT-1]};
          shreg_n = shreg << 1;
          if (rem_sh >= divisor) begin
            rem_n = rem_sh - divisor;
            quo_n = {quo[TOT-2:0], 1'b1};
          end else begin
            rem_n = rem_sh;
            quo_n = {quo[TOT-2:0], 1'b0};
          end
        end

        if (cnt == CW'(1)) begin
          state_n     = DONE;
          out_valid_n = 1'b1;
          if (op_q) begin
`ifdef FP_DIVSQRT_SQRT_EN
            result_n = W'(quo_n);
`endif
          end else if (neg_q) begin
            if (quo_n > NEG_MAG) begin
              result_n = MIN_RES;
              ovf_n    = 1'b1;
            end else begin
              result_n = ~quo_n[W-1:0] + W'(1);
            end
          end else if (quo_n > POS_MAX) begin
            result_n = MAX_RES;
            ovf_n    = 1'b1;
          end else begin
            result_n = quo_n[W-1:0];
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
          result_n    = '0;
          dbz_n       = 1'b0;
          ovf_n       = 1'b0;
          dom_n       = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase

    in_ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_fp_divsqrt_unit.sv
// Self-checking bench for fp_divsqrt_unit: directed divides/sqrts, a reference divide model,
// a scoreboard queue of expected results, output-hold and mid-operation reset checks.
module tb_fp_divsqrt_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        div_by_zero;
  logic        overflow;
  logic        domain_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
    logic        dom;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  fp_divsqrt_unit #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .domain_err  (domain_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t div_model(input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint n, d, q;
    e.dom = 1'b0;
    if (y == 32'h0) begin
      e.res = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.dbz = 1'b1;
      e.ovf = 1'b1;
      e.lat = 1;
    end else begin
      n = longint'($signed(x)) * 65536;
      d = longint'($signed(y));
      q = n / d;
      e.dbz = 1'b0;
      e.lat = 48;
      if (q > 64'sd2147483647) begin
        e.res = 32'h7FFF_FFFF;
        e.ovf = 1'b1;
      end else if (q < -64'sd2147483648) begin
        e.res = 32'h8000_0000;
        e.ovf = 1'b1;
      end else begin
        e.res = q[31:0];
        e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] r, input logic dbz, input logic ovf,
                              input logic dom, input int lat);
    exp_t e;
    e.res = r; e.dbz = dbz; e.ovf = ovf; e.dom = dom; e.lat = lat;
    return e;
  endfunction

  task automatic send(input logic o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic receive(input string tag, input int hold);
    exp_t        e;
    int          lat = 0;
    logic        seen = 1'b0;
    logic [31:0] first;
    e = exp_q.pop_front();
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      seen = out_valid;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_result"}, result, e.res);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
    check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
    check({tag, "_dom"}, 32'(domain_err), 32'(e.dom));
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    first = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_result"}, result, first);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    check({tag, "_in_ready_in_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, "_flags_after"}, {29'd0, div_by_zero, overflow, domain_err}, 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic o, input logic [31:0] x,
                     input logic [31:0] y, input exp_t e, input int hold);
    send(o, x, y);
    exp_q.push_back(e);
    receive(tag, hold);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ra, rb;
    logic        any_valid;

    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, div_by_zero, overflow, domain_err}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run("div_6_2", 1'b0, 32'h0006_0000, 32'h0002_0000, mk(32'h0003_0000, 0, 0, 0, 48), 0);
    run("div_1_0", 1'b0, 32'h0001_0000, 32'h0, mk(32'h7FFF_FFFF, 1, 1, 0, 1), 0);
    run("div_m1_0", 1'b0, 32'hFFFF_0000, 32'h0, mk(32'h8000_0000, 1, 1, 0, 1), 0);
    run("div_sat", 1'b0, 32'h7FFF_0000, 32'h0000_8000, mk(32'h7FFF_FFFF, 0, 1, 0, 48), 0);
    run("div_m6_2", 1'b0, 32'hFFFA_0000, 32'h0002_0000, mk(32'hFFFD_0000, 0, 0, 0, 48), 0);
    run("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_0000, mk(32'h7FFF_FFFF, 0, 1, 0, 48), 0);
    run("div_min_1", 1'b0, 32'h8000_0000, 32'h0001_0000, mk(32'h8000_0000, 0, 0, 0, 48), 0);

`ifdef FP_DIVSQRT_SQRT_EN
    run("sqrt_4", 1'b1, 32'h0004_0000, 32'h0, mk(32'h0002_0000, 0, 0, 0, 24), 0);
    run("sqrt_2", 1'b1, 32'h0002_0000, 32'h1234, mk(32'h0001_6A09, 0, 0, 0, 24), 0);
    run("sqrt_0", 1'b1, 32'h0, 32'h0, mk(32'h0, 0, 0, 0, 24), 0);
`else
    run("sqrt_off_4", 1'b1, 32'h0004_0000, 32'h0, mk(32'h0, 0, 0, 1, 1), 0);
    run("sqrt_off_2", 1'b1, 32'h0002_0000, 32'h1234, mk(32'h0, 0, 0, 1, 1), 0);
`endif
    run("sqrt_neg", 1'b1, 32'h8000_0000, 32'h0, mk(32'h0, 0, 0, 1, 1), 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      if (i == 5) rb = 32'h0;
      e = div_model(ra, rb);
      run("div_rand", 1'b0, ra, rb, e, 0);
    end

    run("div_hold", 1'b0, 32'h0009_0000, 32'hFFFD_0000, mk(32'hFFFD_0000, 0, 0, 0, 48), 10);

    send(1'b0, 32'h0006_0000, 32'h0002_0000);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    check("abort_valid_in_reset", 32'(out_valid), 32'd0);
    check("abort_ready_in_reset", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      any_valid = any_valid | out_valid;
    end
    check("abort_no_valid", 32'(any_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);

    run("div_after_abort", 1'b0, 32'h0006_0000, 32'h0002_0000, mk(32'h0003_0000, 0, 0, 0, 48), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
